// File: rtl/writeback_unit.sv
// Writeback stage: MEM/WB register, load extraction, fault detection
// and the retired-instruction counter.
module writeback_unit #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidM,
  input  logic             RegWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [2:0]       LoadTypeM,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  ReadDataM,
  input  logic [XLEN-1:0]  PCPlus4M,
  input  logic [XLEN-1:0]  ImmExtM,
  input  logic [RA_W-1:0]  RdM,
  input  logic             StallW,
  input  logic             FlushW,
  output logic [XLEN-1:0]  ResultW,
  output logic [RA_W-1:0]  RdW,
  output logic             RegWriteW,
  output logic             LoadFaultW,
  output logic [CNT_W-1:0] InstRetW
);

  localparam bit IS64 = (XLEN == 64);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [1:0]      src;
    logic [2:0]      ltype;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rd;
  } wb_t;

  wb_t              wb_q;
  wb_t              m_in;
  logic [CNT_W-1:0] cnt_q;

  assign m_in = '{
    valid:     ValidM,
    reg_write: RegWriteM,
    src:       ResultSrcM,
    ltype:     LoadTypeM,
    alu:       ALUResultM,
    rdata:     ReadDataM,
    pc4:       PCPlus4M,
    imm:       ImmExtM,
    rd:        RdM
  };

  // Flush only kills valid; the payload is don't-care once invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
    end else if (FlushW) begin
      wb_q.valid <= 1'b0;
    end else if (!StallW) begin
      wb_q <= m_in;
    end
  end

  logic [31:0]     word_v;
  logic [15:0]     half_v;
  logic [7:0]      byte_v;
  logic [XLEN-1:0] load_v;

  always_comb begin
    word_v = wb_q.rdata[31:0];
    half_v = wb_q.alu[1] ? word_v[31:16] : word_v[15:0];
    byte_v = word_v[{wb_q.alu[1:0], 3'b000} +: 8];
    load_v = '0;
    unique case (wb_q.ltype)
      3'b000:  load_v = XLEN'($signed(byte_v));
      3'b100:  load_v = XLEN'(byte_v);
      3'b001:  load_v = XLEN'($signed(half_v));
      3'b101:  load_v = XLEN'(half_v);
      3'b010:  load_v = XLEN'($signed(word_v));
      3'b110:  load_v = XLEN'(word_v);
      3'b011:  load_v = wb_q.rdata;
      default: load_v = '0;
    endcase
  end

  logic illegal;
  logic misalign;

  always_comb begin
    illegal = (wb_q.ltype == 3'b111)
            | (!IS64 & (wb_q.ltype == 3'b011))
            | (!IS64 & (wb_q.ltype == 3'b110));
    misalign = 1'b0;
    unique case (wb_q.ltype[1:0])
      2'b01:   misalign = wb_q.alu[0];
      2'b10:   misalign = (wb_q.alu[1:0] != 2'b00);
      2'b11:   misalign = (wb_q.alu[2:0] != 3'b000);
      default: misalign = 1'b0;
    endcase
  end

  always_comb begin
    ResultW = '0;
    unique case (wb_q.src)
      2'b00: ResultW = wb_q.alu;
      2'b01: ResultW = load_v;
      2'b10: ResultW = wb_q.pc4;
      2'b11: ResultW = wb_q.imm;
    endcase
  end

  assign LoadFaultW = wb_q.valid & (wb_q.src == 2'b01)
                    & (illegal | misalign);
  assign RegWriteW  = wb_q.valid & wb_q.reg_write
                    & (wb_q.rd != '0) & !LoadFaultW;
  assign RdW        = wb_q.rd;

  // A stalled instruction is counted once, on the edge it leaves WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (wb_q.valid & !LoadFaultW & !StallW) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign InstRetW = cnt_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: a 32-bit and a 64-bit/4-bit-counter
// instance share one stimulus stream and a behavioural model.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_m, reg_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  load_type_m;
  logic [63:0] alu_m, rdata_m, pc4_m, imm_m;
  logic [4:0]  rd_m;
  logic        stall, flush;

  logic [31:0] res_a, cnt_a;
  logic [4:0]  rd_a, rd_b;
  logic        rw_a, lf_a, rw_b, lf_b;
  logic [63:0] res_b;
  logic [3:0]  cnt_b;

  int vecs  = 0;
  int fails = 0;

  always #5 clk = ~clk;

  writeback_unit dut_a (
    .clk(clk), .rst(rst),
    .ValidM(valid_m), .RegWriteM(reg_write_m),
    .ResultSrcM(result_src_m), .LoadTypeM(load_type_m),
    .ALUResultM(alu_m[31:0]), .ReadDataM(rdata_m[31:0]),
    .PCPlus4M(pc4_m[31:0]), .ImmExtM(imm_m[31:0]),
    .RdM(rd_m), .StallW(stall), .FlushW(flush),
    .ResultW(res_a), .RdW(rd_a), .RegWriteW(rw_a),
    .LoadFaultW(lf_a), .InstRetW(cnt_a)
  );

  writeback_unit #(.XLEN(64), .RA_W(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .ValidM(valid_m), .RegWriteM(reg_write_m),
    .ResultSrcM(result_src_m), .LoadTypeM(load_type_m),
    .ALUResultM(alu_m), .ReadDataM(rdata_m),
    .PCPlus4M(pc4_m), .ImmExtM(imm_m),
    .RdM(rd_m), .StallW(stall), .FlushW(flush),
    .ResultW(res_b), .RdW(rd_b), .RegWriteW(rw_b),
    .LoadFaultW(lf_b), .InstRetW(cnt_b)
  );

  // Model: the instruction currently sitting in WB plus two counters.
  logic        mv, mrw;
  logic [1:0]  msrc;
  logic [2:0]  mlt;
  logic [63:0] malu, mdata, mpc4, mimm;
  logic [4:0]  mrd;
  logic [31:0] mcnt_a;
  logic [3:0]  mcnt_b;

  function automatic logic [63:0] mask(int xlen, logic [63:0] v);
    return (xlen == 32) ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  function automatic logic [63:0] exp_load(int xlen);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    logic [63:0] r;
    w = mdata[31:0];
    b = 8'(w >> (8 * malu[1:0]));
    h = 16'(w >> (16 * malu[1]));
    case (mlt)
      3'd0:    r = 64'(longint'($signed(b)));
      3'd4:    r = 64'(b);
      3'd1:    r = 64'(longint'($signed(h)));
      3'd5:    r = 64'(h);
      3'd2:    r = 64'(longint'($signed(w)));
      3'd6:    r = 64'(w);
      3'd3:    r = mdata;
      default: r = 64'd0;
    endcase
    return mask(xlen, r);
  endfunction

  function automatic logic exp_fault(int xlen);
    logic   bad;
    longint size;
    if (!mv || msrc != 2'd1) return 1'b0;
    bad = (mlt == 3'd7) ||
          (xlen == 32 && (mlt == 3'd3 || mlt == 3'd6));
    size = longint'(1) << mlt[1:0];
    return bad || ((malu % 64'(size)) != 64'd0);
  endfunction

  function automatic logic [63:0] exp_res(int xlen);
    case (msrc)
      2'd0:    return mask(xlen, malu);
      2'd1:    return exp_load(xlen);
      2'd2:    return mask(xlen, mpc4);
      default: return mask(xlen, mimm);
    endcase
  endfunction

  function automatic logic exp_rw(int xlen);
    return mv && mrw && (mrd != 5'd0) && !exp_fault(xlen);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mcnt_a = '0; mcnt_b = '0;
      mv = 0; mrw = 0; msrc = 0; mlt = 0; mrd = 0;
      malu = 0; mdata = 0; mpc4 = 0; mimm = 0;
    end else begin
      if (mv && !exp_fault(32) && !stall) mcnt_a = mcnt_a + 1;
      if (mv && !exp_fault(64) && !stall) mcnt_b = mcnt_b + 1;
      if (flush) mv = 1'b0;
      else if (!stall) begin
        mv = valid_m; mrw = reg_write_m; msrc = result_src_m;
        mlt = load_type_m; malu = alu_m; mdata = rdata_m;
        mpc4 = pc4_m; mimm = imm_m; mrd = rd_m;
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] src,
                       input logic [2:0] lt, input logic [63:0] alu,
                       input logic [63:0] data, input logic [4:0] rd);
    valid_m = v; reg_write_m = 1'b1; result_src_m = src;
    load_type_m = lt; alu_m = alu; rdata_m = data; rd_m = rd;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 2'd0, 3'd0, 64'h55, 64'h0, 5'd7);
    stall = 1'b1; flush = 1'b1; rst = 1'b1;
    tick();
    vecs++;
    if (rw_a !== 1'b0 || rw_b !== 1'b0) begin
      fails++; $display("FAIL reset_rw: got %b/%b want 0", rw_a, rw_b);
    end
    if (lf_a !== 1'b0 || lf_b !== 1'b0) begin
      fails++; $display("FAIL reset_lf: got %b/%b want 0", lf_a, lf_b);
    end
    if (res_a !== 32'd0 || res_b !== 64'd0) begin
      fails++; $display("FAIL reset_res: got %h/%h want 0", res_a, res_b);
    end
    if (rd_a !== 5'd0 || rd_b !== 5'd0) begin
      fails++; $display("FAIL reset_rd: got %h/%h want 0", rd_a, rd_b);
    end
    if (cnt_a !== 32'd0 || cnt_b !== 4'd0) begin
      fails++; $display("FAIL reset_cnt: got %h/%h want 0", cnt_a, cnt_b);
    end
    // Capture must wait for the first edge with both rst and stall low.
    rst = 1'b0; flush = 1'b0;
    tick();
    if (rw_a !== 1'b0) begin
      fails++; $display("FAIL reset_stall_hold: got %b want 0", rw_a);
    end
    stall = 1'b0;
    tick();
    if (rw_a !== 1'b1 || res_a !== 32'h55) begin
      fails++; $display("FAIL reset_first_cap: got %b %h want 1 55",
                        rw_a, res_a);
    end
  endtask

  task automatic test_load_sign();
    do_reset();
    drive(1'b1, 2'd1, 3'b000, 64'h1003, 64'h80FF7F01, 5'd3);
    tick();
    vecs++;
    if (res_a !== 32'hFFFFFF80 || rw_a !== 1'b1) begin
      fails++; $display("FAIL lb32: got %h %b want ffffff80 1", res_a, rw_a);
    end
    if (res_b !== 64'hFFFFFFFFFFFFFF80) begin
      fails++; $display("FAIL lb64: got %h want ffffffffffffff80", res_b);
    end
    load_type_m = 3'b100;
    tick();
    if (res_a !== 32'h80 || res_b !== 64'h80) begin
      fails++; $display("FAIL lbu: got %h/%h want 80", res_a, res_b);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    drive(1'b1, 2'd1, 3'b001, 64'h1001, 64'h12345678, 5'd5);
    tick();
    vecs++;
    if (lf_a !== 1'b1 || lf_b !== 1'b1) begin
      fails++; $display("FAIL lh_fault: got %b/%b want 1", lf_a, lf_b);
    end
    if (rw_a !== 1'b0 || rw_b !== 1'b0) begin
      fails++; $display("FAIL lh_rw: got %b/%b want 0", rw_a, rw_b);
    end
    valid_m = 1'b0;
    tick();
    if (cnt_a !== 32'd0 || cnt_b !== 4'd0) begin
      fails++; $display("FAIL lh_cnt: got %h/%h want 0", cnt_a, cnt_b);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 2'd2, 3'd0, 64'h0, 64'h0, 5'd1);
    pc4_m = 64'h104;
    tick();
    vecs++;
    if (res_a !== 32'h104 || rw_a !== 1'b1) begin
      fails++; $display("FAIL stall_cap: got %h %b want 104 1", res_a, rw_a);
    end
    stall = 1'b1; pc4_m = 64'h200; rd_m = 5'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (res_a !== 32'h104 || rw_a !== 1'b1 || rd_a !== 5'd1) begin
        fails++; $display("FAIL stall_hold%0d: got %h %b %0d want 104 1 1",
                          i, res_a, rw_a, rd_a);
      end
      if (cnt_a !== 32'd0) begin
        fails++; $display("FAIL stall_cnt%0d: got %0d want 0", i, cnt_a);
      end
    end
    stall = 1'b0; valid_m = 1'b0;
    tick();
    tick();
    if (cnt_a !== 32'd1 || cnt_b !== 4'd1) begin
      fails++; $display("FAIL stall_retire: got %0d/%0d want 1", cnt_a, cnt_b);
    end
  endtask

  task automatic test_flush_x0();
    do_reset();
    drive(1'b1, 2'd0, 3'd0, 64'h5, 64'h0, 5'd2);
    tick();
    vecs++;
    flush = 1'b1; stall = 1'b1;
    tick();
    if (rw_a !== 1'b0 || rw_b !== 1'b0) begin
      fails++; $display("FAIL flush_rw: got %b/%b want 0", rw_a, rw_b);
    end
    flush = 1'b0; stall = 1'b0; rd_m = 5'd0;
    tick();
    if (rw_a !== 1'b0) begin
      fails++; $display("FAIL x0_rw: got %b want 0", rw_a);
    end
    valid_m = 1'b0;
    tick();
    if (cnt_a !== mcnt_a || cnt_a !== 32'd1) begin
      fails++; $display("FAIL x0_cnt: got %0d want 1", cnt_a);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 2'd0, 3'd0, 64'h0, 64'h0, 5'd4);
    for (int i = 0; i < 17; i++) begin
      alu_m = {$urandom, $urandom};
      tick();
    end
    valid_m = 1'b0;
    tick();
    vecs++;
    if (cnt_b !== 4'd1) begin
      fails++; $display("FAIL wrap_cnt4: got %0d want 1", cnt_b);
    end
    if (cnt_a !== 32'd17) begin
      fails++; $display("FAIL b2b_cnt32: got %0d want 17", cnt_a);
    end
    valid_m = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (cnt_a !== 32'd0 || cnt_b !== 4'd0 || rw_a !== 1'b0) begin
      fails++; $display("FAIL mid_rst: got %0d/%0d %b want 0/0 0",
                        cnt_a, cnt_b, rw_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      valid_m = ($urandom_range(0, 4) != 0);
      reg_write_m = ($urandom_range(0, 5) != 0);
      result_src_m = 2'($urandom);
      load_type_m = 3'($urandom);
      alu_m = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) alu_m[2:0] = 3'd0;
      rdata_m = {$urandom, $urandom};
      pc4_m = {$urandom, $urandom};
      imm_m = {$urandom, $urandom};
      rd_m = 5'($urandom);
      tick();
      vecs++;
      if (rw_a !== exp_rw(32)) begin
        fails++; $display("FAIL rnd_rw32 #%0d: got %b want %b",
                          i, rw_a, exp_rw(32));
      end
      if (rw_b !== exp_rw(64)) begin
        fails++; $display("FAIL rnd_rw64 #%0d: got %b want %b",
                          i, rw_b, exp_rw(64));
      end
      if (lf_a !== exp_fault(32)) begin
        fails++; $display("FAIL rnd_lf32 #%0d: got %b want %b",
                          i, lf_a, exp_fault(32));
      end
      if (lf_b !== exp_fault(64)) begin
        fails++; $display("FAIL rnd_lf64 #%0d: got %b want %b",
                          i, lf_b, exp_fault(64));
      end
      if (cnt_a !== mcnt_a || cnt_b !== mcnt_b) begin
        fails++; $display("FAIL rnd_cnt #%0d: got %0d/%0d want %0d/%0d",
                          i, cnt_a, cnt_b, mcnt_a, mcnt_b);
      end
      if (mv && !exp_fault(32) && res_a !== exp_res(32)) begin
        fails++; $display("FAIL rnd_res32 #%0d: got %h want %h",
                          i, res_a, exp_res(32));
      end
      if (mv && !exp_fault(64) && res_b !== exp_res(64)) begin
        fails++; $display("FAIL rnd_res64 #%0d: got %h want %h",
                          i, res_b, exp_res(64));
      end
      if (mv && (rd_a !== mrd || rd_b !== mrd)) begin
        fails++; $display("FAIL rnd_rd #%0d: got %0d/%0d want %0d",
                          i, rd_a, rd_b, mrd);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 2'd0, 3'd0, 64'h0, 64'h0, 5'd0);
    pc4_m = 64'h0; imm_m = 64'h0;
    test_reset();
    test_load_sign();
    test_misaligned();
    test_stall();
    test_flush_x0();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width (32 or 64); RA_W, default 5, register-address width; CNT_W, default 32, retire-counter width.
REQ-002 Ports SHALL be, clock and reset first:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- ValidM  input  1  MEM-stage instruction valid
- RegWriteM  input  1  instruction writes rd
- ResultSrcM  input  2  00 ALU, 01 load, 10 PC+4, 11 immediate
- LoadTypeM  input  3  load funct3
- ALUResultM  input  XLEN  ALU result / load address
- ReadDataM  input  XLEN  raw data-memory word
- PCPlus4M  input  XLEN  PC+4
- ImmExtM  input  XLEN  extended immediate
- RdM  input  RA_W  destination register
- StallW  input  1  hold WB register
- FlushW  input  1  invalidate WB register
- ResultW  output  XLEN  register-file write data
- RdW  output  RA_W  register-file write address
- RegWriteW  output  1  register-file write enable
- LoadFaultW  output  1  misaligned or illegal load in WB
- InstRetW  output  CNT_W  retired-instruction count
REQ-003 The clock SHALL be clk; reset SHALL be rst, synchronous and active-high; there SHALL be no other clock or reset.

Function
REQ-004 An internal MEM/WB register SHALL capture all M-side inputs on each rising edge with latency exactly one cycle.
- Priority per edge: rst > FlushW (valid cleared, other fields don't-care) > StallW (hold all fields) > capture.
REQ-005 Result select from registered fields: 00 ALUResult; 01 extracted load data; 10 PCPlus4; 11 ImmExt.
REQ-006 Load extraction SHALL use registered ALUResult low bits as byte offset into the low 32 bits of ReadData:
- 000 LB: byte[addr[1:0]], sign-extend to XLEN; 100 LBU: zero-extend.
- 001 LH: halfword[addr[1]], sign-extend; 101 LHU: zero-extend.
- 010 LW: low 32 bits, sign-extend to XLEN; 110 LWU: zero-extend, legal only when XLEN=64.
- 011 LD: full word, legal only when XLEN=64 with addr[2:0]=0.
REQ-007 Load fault SHALL be set when ResultSrc=01, valid, and either LoadType is illegal for XLEN (including 111) or the address is misaligned (LH/LHU addr[0]=1; LW/LWU addr[1:0]!=0; LD addr[2:0]!=0).
REQ-008 LoadFaultW = valid & load fault; combinational from the WB register.
REQ-009 RegWriteW = valid & RegWrite & (Rd!=0) & !LoadFaultW; while StallW is high it SHALL remain asserted (idempotent rewrite).
REQ-010 RdW SHALL equal the registered Rd; ResultW SHALL be the REQ-005 value regardless of RegWriteW.
REQ-011 InstRetW SHALL increment by 1 on each edge where WB holds valid, LoadFaultW=0 and StallW=0; it SHALL wrap from 2^CNT_W-1 to 0.
REQ-012 FlushW and StallW high in the same cycle: flush wins; the retire counter still counts the retiring instruction if REQ-011 holds.
REQ-013 An x0 destination SHALL count as retired but SHALL NOT write.

Reset
REQ-014 While rst is high at an edge: valid cleared, InstRetW=0; outputs after that edge: RegWriteW=0, LoadFaultW=0, ResultW=0, RdW=0.
REQ-015 rst asserted mid-stall or mid-flush SHALL override both; the first capture SHALL occur on the first edge with rst low and StallW low.

Verification
REQ-016 LB, ReadDataM=0x80FF7F01, ALUResultM=0x1003 -> next cycle ResultW=0xFFFFFF80, RegWriteW=1; same with LBU -> 0x00000080.
REQ-017 LH with ALUResultM=0x1001, RdM=5 -> LoadFaultW=1, RegWriteW=0, InstRetW unchanged.
REQ-018 ResultSrcM=10, PCPlus4M=0x104, RdM=1, then StallW=1 for 3 cycles -> ResultW=0x104, RegWriteW=1 all 4 cycles, InstRetW +1 only once.
REQ-019 FlushW and StallW both high with valid instruction -> next cycle RegWriteW=0; RdM=0 with RegWriteM=1 -> RegWriteW=0, InstRetW +1.
REQ-020 CNT_W=4, 17 back-to-back valid retirements from reset -> InstRetW=1; rst pulse mid-stream -> InstRetW=0, RegWriteW=0 next cycle.
